operand_entry: RTL

OPERAND_ENTRY -- requirements
Module: operand_entry

---
 rtl/operand_entry.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/operand_entry.sv
`default_nettype none
// ============================================================================
// Module      : operand_entry
// Description : Calculator operand entry. Takes key events from a keypad
//               controller over a four-phase handshake, builds two signed
//               operands digit by digit, latches the arithmetic operator,
//               starts the arithmetic unit on "=", and chains its result
//               into the next calculation.
// Ports       : clk, nRST                 - clock, async active-low reset
//               read_input / key_read     - key-available / acknowledge
//               keypad_input              - digit 0-9 (others discarded)
//               operator_input            - 001 sign, 010 add, 011 sub,
//                                           100 mul, 000 none
//               equal_input               - equals key
//               operand_a, operand_b      - two's-complement operands
//               op_code                   - latched arithmetic operator
//               calc_start / calc_done    - arithmetic unit request/complete
//               calc_result               - arithmetic result
//               display_value             - value shown to the user
//               entry_ovf                 - entry overflow (ENTRY_OVF_EN only)
// Config      : `define ENTRY_OVF_EN to reject digits that would push an
//               operand magnitude past 32767 and flag entry_ovf; otherwise
//               accumulation wraps modulo 2^16.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_entry (
    input  logic        clk,
    input  logic        nRST,
    input  logic        read_input,
    output logic        key_read,
    input  logic [3:0]  keypad_input,
    input  logic [2:0]  operator_input,
    input  logic        equal_input,
    output logic [15:0] operand_a,
    output logic [15:0] operand_b,
    output logic [2:0]  op_code,
    output logic        calc_start,
    input  logic        calc_done,
    input  logic [15:0] calc_result,
    output logic [15:0] display_value
`ifdef ENTRY_OVF_EN
    ,
    output logic        entry_ovf
`endif
);

    typedef enum logic [0:0] {H_IDLE = 1'b0, H_ACK = 1'b1} hs_state_t;
    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        SHOW    = 2'd3
    } main_state_t;

    localparam logic [2:0] c_OP_SIGN = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_MUL  = 3'b100;

    hs_state_t   r_hs_state;
    main_state_t r_main_state;
    logic        r_armed;
    logic        r_key_read;
    logic        r_calc_start;
    logic [15:0] r_mag_a;
    logic [15:0] r_mag_b;
    logic        r_sign_a;
    logic        r_sign_b;
    logic [2:0]  r_op_code;
    logic [15:0] r_result;
`ifdef ENTRY_OVF_EN
    logic        r_entry_ovf;
`endif

    // A key event is the first sampled-high cycle of read_input, and only
    // once read_input has been seen low since reset.
    logic        w_key_evt;
    logic        w_is_eq;
    logic        w_is_sign;
    logic        w_is_arith;
    logic        w_is_digit;
    logic [15:0] w_mag_sel;
    logic [15:0] w_acc;
    logic        w_digit_ok;

    assign w_key_evt  = (r_hs_state == H_IDLE) && read_input && r_armed;
    // Priority: equals, then any non-zero operator code, then digit.
    // Unknown operator codes swallow the key rather than falling to digit.
    assign w_is_eq    = equal_input;
    assign w_is_sign  = !equal_input && (operator_input == c_OP_SIGN);
    assign w_is_arith = !equal_input && (operator_input >= c_OP_ADD)
                                     && (operator_input <= c_OP_MUL);
    assign w_is_digit = !equal_input && (operator_input == 3'b000)
                                     && (keypad_input <= 4'd9);

    assign w_mag_sel  = (r_main_state == ENTER_B) ? r_mag_b : r_mag_a;
    assign w_acc      = w_mag_sel * 16'd10 + {12'd0, keypad_input};

`ifdef ENTRY_OVF_EN
    logic [19:0] w_acc_wide;
    assign w_acc_wide = {4'd0, w_mag_sel} * 20'd10 + {16'd0, keypad_input};
    assign w_digit_ok = (w_acc_wide <= 20'd32767);
    assign entry_ovf  = r_entry_ovf;
`else
    assign w_digit_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_hs_state   <= H_IDLE;
            r_main_state <= ENTER_A;
            r_armed      <= 1'b0;
            r_key_read   <= 1'b0;
            r_calc_start <= 1'b0;
            r_mag_a      <= 16'd0;
            r_mag_b      <= 16'd0;
            r_sign_a     <= 1'b0;
            r_sign_b     <= 1'b0;
            r_op_code    <= 3'b000;
            r_result     <= 16'd0;
`ifdef ENTRY_OVF_EN
            r_entry_ovf  <= 1'b0;
`endif
        end else begin
            r_calc_start <= 1'b0;

            // Keypad handshake
            case (r_hs_state)
                H_IDLE: begin
                    if (!read_input) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_key_read <= 1'b1;
                        r_hs_state <= H_ACK;
                    end
                end
                H_ACK: begin
                    if (!read_input) begin
                        r_key_read <= 1'b0;
                        r_hs_state <= H_IDLE;
                    end
                end
                default: r_hs_state <= H_IDLE;
            endcase

            // Operand entry
            case (r_main_state)
                ENTER_A: begin
                    if (w_key_evt) begin
                        if (w_is_digit) begin
                            if (w_digit_ok) begin
                                r_mag_a <= w_acc;
                            end
`ifdef ENTRY_OVF_EN
                            else begin
                                r_entry_ovf <= 1'b1;
                            end
`endif
                        end else if (w_is_sign) begin
                            r_sign_a <= !r_sign_a;
                        end else if (w_is_arith) begin
                            r_op_code    <= operator_input;
                            r_mag_b      <= 16'd0;
                            r_sign_b     <= 1'b0;
                            r_main_state <= ENTER_B;
`ifdef ENTRY_OVF_EN
                            r_entry_ovf  <= 1'b0;
`endif
                        end
                    end
                end
                ENTER_B: begin
                    if (w_key_evt) begin
                        if (w_is_eq) begin
                            r_calc_start <= 1'b1;
                            r_main_state <= CALC;
                        end else if (w_is_digit) begin
                            if (w_digit_ok) begin
                                r_mag_b <= w_acc;
                            end
`ifdef ENTRY_OVF_EN
                            else begin
                                r_entry_ovf <= 1'b1;
                            end
`endif
                        end else if (w_is_sign) begin
                            r_sign_b <= !r_sign_b;
                        end else if (w_is_arith) begin
                            r_op_code <= operator_input;
                        end
                    end
                end
                CALC: begin
                    // Keys arriving here are acknowledged by the handshake
                    // but never reach the operands.
                    if (calc_done) begin
                        r_result     <= calc_result;
                        r_main_state <= SHOW;
                    end
                end
                SHOW: begin
                    if (w_key_evt) begin
                        if (w_is_digit) begin
                            r_mag_a      <= {12'd0, keypad_input};
                            r_sign_a     <= 1'b0;
                            r_main_state <= ENTER_A;
`ifdef ENTRY_OVF_EN
                            r_entry_ovf  <= 1'b0;
`endif
                        end else if (w_is_arith) begin
                            // Chain: previous result becomes operand A.
                            r_mag_a      <= r_result;
                            r_sign_a     <= 1'b0;
                            r_op_code    <= operator_input;
                            r_mag_b      <= 16'd0;
                            r_sign_b     <= 1'b0;
                            r_main_state <= ENTER_B;
`ifdef ENTRY_OVF_EN
                            r_entry_ovf  <= 1'b0;
`endif
                        end else if (w_is_sign) begin
                            r_mag_a      <= r_result;
                            r_sign_a     <= 1'b1;
                            r_main_state <= ENTER_A;
`ifdef ENTRY_OVF_EN
                            r_entry_ovf  <= 1'b0;
`endif
                        end
                    end
                end
                default: r_main_state <= ENTER_A;
            endcase
        end
    end

    assign key_read   = r_key_read;
    assign calc_start = r_calc_start;
    assign op_code    = r_op_code;
    assign operand_a  = r_sign_a ? (~r_mag_a + 16'd1) : r_mag_a;
    assign operand_b  = r_sign_b ? (~r_mag_b + 16'd1) : r_mag_b;

    always_comb begin
        display_value = operand_a;
        case (r_main_state)
            ENTER_A:      display_value = operand_a;
            ENTER_B,
            CALC:         display_value = operand_b;
            SHOW:         display_value = r_result;
            default:      display_value = operand_a;
        endcase
    end

endmodule
`default_nettype wire
